// File: rtl/lsu_mem_bridge_pkg.sv
// Shared types and RV32I load/store funct3 encodings
// for the LSU memory bridge.
package lsu_mem_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_RESP
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, extraction/extension
// for loads, and legality/alignment check.
module lsu_lane_align
  import lsu_mem_bridge_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [1:0]  off;
  logic [31:0] shifted;

  assign off     = addr_i[1:0];
  assign shifted = rdata_i >> {off, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    bad_o   = 1'b0;
    if (we_i) begin
      case (funct3_i)
        SB: begin
          be_o    = 4'b0001 << off;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SH: begin
          be_o    = 4'b0011 << off;
          wdata_o = {2{wdata_i[15:0]}};
          bad_o   = off[0];
        end
        SW: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
          bad_o   = |off;
        end
        default: bad_o = 1'b1;
      endcase
    end else begin
      be_o = 4'b1111;
      case (funct3_i)
        LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
        LBU: rdata_o = {24'h0, shifted[7:0]};
        LH: begin
          rdata_o = {{16{shifted[15]}}, shifted[15:0]};
          bad_o   = off[0];
        end
        LHU: begin
          rdata_o = {16'h0, shifted[15:0]};
          bad_o   = off[0];
        end
        LW: begin
          rdata_o = rdata_i;
          bad_o   = |off;
        end
        default: bad_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store unit bridging the core data port to a
// variable-latency word memory, with stall and timeout.
module lsu_mem_bridge
  import lsu_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic        idle, in_req, in_wait, in_resp;
  logic        a_we, a_bad, to_hit;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata_in;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;

  assign idle    = (state_q == S_IDLE);
  assign in_req  = (state_q == S_REQ);
  assign in_wait = (state_q == S_WAIT_R);
  assign in_resp = (state_q == S_RESP);
  assign to_hit  = (cnt_q >= TO_LAST);

  // Decode the live request in IDLE, the latched one after.
  assign a_we       = idle ? req_we     : we_q;
  assign a_f3       = idle ? req_funct3 : f3_q;
  assign a_addr     = idle ? req_addr   : addr_q;
  assign a_wdata_in = idle ? req_wdata  : wdata_q;

  lsu_lane_align u_align (
    .we_i     (a_we),
    .funct3_i (a_f3),
    .addr_i   (a_addr),
    .wdata_i  (a_wdata_in),
    .rdata_i  (mem_rdata),
    .be_o     (a_be),
    .wdata_o  (a_wdata),
    .rdata_o  (a_rdata),
    .bad_o    (a_bad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
          if (req_valid) begin
            if (a_bad) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              we_q    <= req_we;
              f3_q    <= req_funct3;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_gnt) begin
            state_q <= we_q ? S_RESP : S_WAIT_R;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_WAIT_R: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) begin
            rdata_q <= a_rdata;
            state_q <= S_RESP;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall = (idle & req_valid & ~reset)
               | in_req | in_wait;

  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp & err_q;
  assign rsp_rdata = in_resp ? rdata_q : 32'h0;

  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_be    = in_req ? a_be : 4'b0000;
  assign mem_wdata = in_req ? a_wdata : 32'h0;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00}
                            : 32'h0;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: table-driven
// accesses, timeout, and mid-transaction reset.
module tb_lsu_mem_bridge;
  import lsu_mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] sb_q[$];

  lsu_mem_bridge #(.TIMEOUT(8), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexp_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
        chk("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  // Called at posedge+1 with the DUT idle.
  task automatic access(input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int gnt_d,
                        input int rv_d,
                        input logic [31:0] rd,
                        input int exp_reqc,
                        input logic [3:0] exp_be,
                        input logic [31:0] exp_wd,
                        input logic exp_err,
                        input logic [31:0] exp_rd);
    int k;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    sb_q.push_back({exp_err, exp_rd});
    #1;
    chk("stall_idle", {31'h0, stall}, 32'd1);
    chk("mreq_idle", {31'h0, mem_req}, 32'd0);
    @(posedge clk); #1;
    k = 0;
    while (mem_req === 1'b1 && k < 40) begin
      chk("mem_addr", mem_addr,
          {addr[31:2], 2'b00});
      chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
      chk("mem_we", {31'h0, mem_we}, {31'h0, we});
      chk("stall_req", {31'h0, stall}, 32'd1);
      if (we) chk("mem_wdata", mem_wdata, exp_wd);
      mem_gnt = (k == gnt_d);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      k++;
    end
    chk("req_cycles", k, exp_reqc);
    for (int j = 1; j <= rv_d; j++) begin
      chk("mreq_wait", {31'h0, mem_req}, 32'd0);
      chk("stall_wait", {31'h0, stall}, 32'd1);
      mem_rvalid = (j == rv_d);
      mem_rdata  = (j == rv_d) ? rd : 32'h5A5A_5A5A;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("stall_resp", {31'h0, stall}, 32'd0);
    chk("mreq_resp", {31'h0, mem_req}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sb_drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",
        {27'h0, stall, rsp_valid, rsp_err,
         mem_req, mem_we}, 32'd0);
    chk("rst_be", {28'h0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wd", mem_wdata, 32'd0);
    chk("rst_rd", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     we  f3   addr      wdata         g  rv rdata
    access(1, SB, 32'h65, 32'h1234_56AB, 0, 0, 32'h0,
           1, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
    access(1, SH, 32'h66, 32'h0000_BEEF, 0, 0, 32'h0,
           1, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
    access(1, SW, 32'h70, 32'hDEAD_BEEF, 3, 0, 32'h0,
           4, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0);
    access(0, LH, 32'h62, 32'h0, 0, 2, 32'h8001_1234,
           1, 4'b1111, 32'h0, 0, 32'hFFFF_8001);
    access(0, LHU, 32'h62, 32'h0, 0, 2, 32'h8001_1234,
           1, 4'b1111, 32'h0, 0, 32'h0000_8001);
    access(0, LBU, 32'h63, 32'h0, 0, 2, 32'h8001_1234,
           1, 4'b1111, 32'h0, 0, 32'h0000_0080);
    access(0, LB, 32'h63, 32'h0, 1, 1, 32'h8001_1234,
           2, 4'b1111, 32'h0, 0, 32'hFFFF_FF80);
    access(0, LB, 32'h60, 32'h0, 0, 1, 32'h8001_1234,
           1, 4'b1111, 32'h0, 0, 32'h0000_0034);
    access(0, LW, 32'h60, 32'h0, 0, 1, 32'hCAFE_F00D,
           1, 4'b1111, 32'h0, 0, 32'hCAFE_F00D);
    // Rejected before any memory request.
    access(0, LW, 32'h61, 32'h0, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 1, 32'h0);
    access(1, SH, 32'h61, 32'h1, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 1, 32'h0);
    access(0, 3'b011, 32'h60, 32'h0, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 1, 32'h0);
    access(1, 3'b100, 32'h60, 32'h0, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 1, 32'h0);
    // Timeout, then grant on the last allowed cycle.
    access(0, LW, 32'h80, 32'h0, 99, 0, 32'h0,
           8, 4'b1111, 32'h0, 1, 32'h0);
    access(1, SW, 32'h84, 32'h0BAD_F00D, 7, 0, 32'h0,
           8, 4'b1111, 32'h0BAD_F00D, 0, 32'h0);

    // Reset in WAIT_R.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = LW;
    req_addr   = 32'h40;
    @(posedge clk); #1;
    chk("rq_req", {31'h0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rq_wait", {31'h0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rq_ctl",
        {29'h0, stall, rsp_valid, mem_req}, 32'd0);
    chk("rq_addr", mem_addr, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("rq_quiet",
        {30'h0, rsp_valid, stall}, 32'd0);
    access(0, LW, 32'h40, 32'h0, 0, 1, 32'h0000_0019,
           1, 4'b1111, 32'h0, 0, 32'h0000_0019);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
